// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
//
// Memory-side responder for the system bus. Takes one line request at a
// time: a read returns BEATS response beats tagged with the request tag, and
// a write absorbs BEATS data beats on the request channel. The backing store
// is word addressed and never cleared.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   bus_reqcyc    request beat valid
//   bus_req       address beat, then write data beats
//   bus_reqtag    request tag; MSB = 1 read, 0 write
//   bus_reqack    responder accepts a request beat this cycle
//   bus_respcyc   response beat valid
//   bus_resp      response data beat (0 when bus_respcyc = 0)
//   bus_resptag   tag of the request being answered (0 when bus_respcyc = 0)
//   bus_respack   initiator consumes the response beat
//
// State    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for an address beat
// WDATA    | absorbing write data beats into the line
// RWAIT    | read latency countdown
// RBURST   | presenting read beats in ascending order until all consumed
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam int LW = AW - BW;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    RWAIT,
    RBURST
  } state_t;

  state_t state, state_nxt;

  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [LW-1:0]             line_q;
  logic [BW-1:0]             beat_q;
  logic [CW-1:0]             cnt_q;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic          req_xfer;
  logic          resp_xfer;
  logic          last_beat;
  logic [AW-1:0] mem_idx;

  // Address bits outside the line index are ignored: the low six select a
  // byte within the 64-byte line, the upper ones wrap modulo memory size.
  logic unused_req_bits;
  assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:LW+6], bus_req[5:0]};

  // Reset is synchronous, so the state register still holds its old value
  // while reset is high; gate the ack so no beat looks accepted then.
  assign bus_reqack = !reset && ((state == IDLE) || (state == WDATA));
  assign req_xfer   = bus_reqcyc && bus_reqack;
  assign resp_xfer  = (state == RBURST) && bus_respack;
  assign last_beat  = (beat_q == BW'(BEATS - 1));
  assign mem_idx    = {line_q, beat_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    case (state)
      IDLE: begin
        if (req_xfer) begin
          state_nxt = bus_reqtag[BUS_TAG_WIDTH-1] ? RWAIT : WDATA;
        end
      end
      WDATA: begin
        if (req_xfer && last_beat) begin
          state_nxt = IDLE;
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_nxt = RBURST;
        end
      end
      RBURST: begin
        bus_respcyc = 1'b1;
        bus_resp    = mem[mem_idx];
        bus_resptag = tag_q;
        if (resp_xfer && last_beat) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter is loaded with READ_LATENCY-1: RWAIT then lasts READ_LATENCY
  // cycles, so the first beat appears READ_LATENCY edges after the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q  <= '0;
      line_q <= '0;
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_xfer) begin
            tag_q  <= bus_reqtag;
            line_q <= bus_req[LW+5:6];
            beat_q <= '0;
            cnt_q  <= CW'(READ_LATENCY - 1);
          end
        end
        WDATA: begin
          if (req_xfer) begin
            beat_q <= beat_q + BW'(1);
          end
        end
        RWAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RBURST: begin
          if (resp_xfer) begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Backing store has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state == WDATA) && req_xfer) begin
      mem[mem_idx] <= bus_req;
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
module tb_sysbus_mem_responder;

  localparam int DW        = 64;
  localparam int TW        = 13;
  localparam int MEM_WORDS = 4096;
  localparam int LAT       = 4;
  localparam int BEATS     = 8;

  logic          clk;
  logic          reset;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .MEM_WORDS     (MEM_WORDS),
    .READ_LATENCY  (LAT),
    .BEATS         (BEATS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  logic [DW-1:0]    mem_model [int];
  logic [TW+DW-1:0] q_exp [$];
  logic [DW-1:0]    wr_addrs [$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Line base word index: byte address / 64 bytes per line, modulo lines in memory.
  function automatic int line_base(input logic [63:0] addr);
    return int'((addr >> 6) % 64'(MEM_WORDS / BEATS)) * BEATS;
  endfunction

  function automatic logic ack_pat(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Scoreboard monitor: pops one expected beat per response transfer.
  initial begin : monitor
    bit               prev_stall;
    logic [DW-1:0]    prev_d;
    logic [TW-1:0]    prev_t;
    logic [TW+DW-1:0] e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_t = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_respcyc === 1'b1) begin
          if (prev_stall) begin
            chk(bus_resp === prev_d, "stall_data", bus_resp, prev_d);
            chk(bus_resptag === prev_t, "stall_tag", 64'(bus_resptag), 64'(prev_t));
          end
          if (bus_respack === 1'b1) begin
            if (q_exp.size() == 0) begin
              chk(1'b0, "unexpected_beat", bus_resp, 64'(0));
            end else begin
              e = q_exp.pop_front();
              chk(bus_resp === e[DW-1:0], "resp_data", bus_resp, e[DW-1:0]);
              chk(bus_resptag === e[TW+DW-1:DW], "resp_tag", 64'(bus_resptag), 64'(e[TW+DW-1:DW]));
            end
          end
          prev_stall = (bus_respack !== 1'b1);
          prev_d     = bus_resp;
          prev_t     = bus_resptag;
        end else begin
          chk(bus_resp === '0 && bus_resptag === '0 && bus_respcyc === 1'b0, "idle_zero",
              bus_resp | 64'(bus_resptag), 64'(0));
          prev_stall = 1'b0;
        end
      end
    end
  end

  task automatic issue_addr(input logic [63:0] addr, input logic [TW-1:0] tag);
    int n;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    n = 0;
    while (bus_reqack !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk(1'b0, "reqack_timeout", 64'(bus_reqack), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [TW-1:0] tag, input logic [DW-1:0] d [BEATS]);
    int base;
    base = line_base(addr);
    issue_addr(addr, tag);
    for (int b = 0; b < BEATS; b++) begin
      bus_req    = d[b];
      bus_reqtag = TW'($urandom);
      chk(bus_reqack === 1'b1, "wr_reqack", 64'(bus_reqack), 64'(1));
      @(posedge clk); #1;
      mem_model[base + b] = d[b];
    end
    bus_reqcyc = 1'b0;
    wr_addrs.push_back(addr);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [TW-1:0] tag, input int mode, input bit hold);
    int base, lat, cyc, n, bad_ack, stray;
    base = line_base(addr);
    for (int b = 0; b < BEATS; b++) q_exp.push_back({tag, mem_model[base + b]});
    issue_addr(addr, tag);
    if (hold) begin
      bus_req    = {$urandom, $urandom};
      bus_reqtag = TW'($urandom) | 13'h1000;
    end else begin
      bus_reqcyc = 1'b0;
    end
    lat = 0;
    cyc = 0;
    bad_ack = 0;
    bus_respack = ack_pat(mode, cyc++);
    while (bus_respcyc !== 1'b1 && lat < 64) begin
      if (bus_reqack !== 1'b0) bad_ack++;
      @(posedge clk); #1;
      lat++;
      bus_respack = ack_pat(mode, cyc++);
    end
    chk(lat == LAT, "read_latency", 64'(lat), 64'(LAT));
    n = 0;
    while (q_exp.size() != 0 && n < 400) begin
      if (bus_reqack !== 1'b0) bad_ack++;
      @(posedge clk); #1;
      n++;
      bus_respack = ack_pat(mode, cyc++);
    end
    chk(q_exp.size() == 0, "burst_done", 64'(q_exp.size()), 64'(0));
    chk(bad_ack == 0, "reqack_busy", 64'(bad_ack), 64'(0));
    chk(bus_reqack === 1'b1 && bus_respcyc === 1'b0, "idle_after_read",
        {62'(0), bus_reqack, bus_respcyc}, 64'(2));
    bus_reqcyc = 1'b0;
    if (hold) begin
      stray = 0;
      repeat (LAT + 2) begin
        @(posedge clk); #1;
        if (bus_respcyc !== 1'b0) stray++;
      end
      chk(stray == 0, "no_second_capture", 64'(stray), 64'(0));
    end
  endtask

  initial begin : stim
    logic [DW-1:0] d [BEATS];
    logic [63:0]   a;
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk(bus_respcyc === 1'b0, "rst_respcyc", 64'(bus_respcyc), 64'(0));
    chk(bus_resp === '0, "rst_resp", bus_resp, 64'(0));
    chk(bus_resptag === '0, "rst_resptag", 64'(bus_resptag), 64'(0));
    chk(bus_reqack === 1'b0, "rst_reqack_low", 64'(bus_reqack), 64'(0));
    reset = 1'b0;
    #1;
    chk(bus_reqack === 1'b1, "reqack_after_rst", 64'(bus_reqack), 64'(1));
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Line at word 0x40 = 0xA0..0xA7, then read back
    for (int b = 0; b < BEATS; b++) d[b] = 64'hA0 + 64'(b);
    do_write(64'h200, 13'h0005, d);
    do_read(64'h200, 13'h1005, 0, 1'b0);

    // Write 0x11..0x88 at 0x1000 and read back
    for (int b = 0; b < BEATS; b++) d[b] = 64'h11 * 64'(b + 1);
    do_write(64'h1000, 13'h0003, d);
    do_read(64'h1000, 13'h1003, 0, 1'b0);

    // Backpressure pattern 1,0,0,1,...
    do_read(64'h200, 13'h1111, 1, 1'b0);

    // Out-of-range address with nonzero low bits wraps to line 0
    for (int b = 0; b < BEATS; b++) d[b] = 64'hC0DE_0000_0000_0000 | 64'(b);
    do_write(64'h0, 13'h0042, d);
    do_read(64'h0008_0038, 13'h1042, 0, 1'b0);

    // Reset while beat 3 of a burst is presented
    for (int b = 0; b < BEATS; b++) q_exp.push_back({13'h1ABC, mem_model[line_base(64'h200) + b]});
    bus_respack = 1'b1;
    issue_addr(64'h200, 13'h1ABC);
    bus_reqcyc = 1'b0;
    begin
      int n;
      n = 0;
      while (bus_respcyc !== 1'b1 && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      chk(n == LAT, "rst_test_latency", 64'(n), 64'(LAT));
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus_respack = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk(bus_respcyc === 1'b0, "midrst_respcyc", 64'(bus_respcyc), 64'(0));
    chk(bus_resp === '0, "midrst_resp", bus_resp, 64'(0));
    chk(bus_resptag === '0, "midrst_resptag", 64'(bus_resptag), 64'(0));
    reset = 1'b0;
    #1;
    chk(bus_reqack === 1'b1, "midrst_reqack", 64'(bus_reqack), 64'(1));
    chk(q_exp.size() == BEATS - 3, "midrst_beats_taken", 64'(q_exp.size()), 64'(BEATS - 3));
    q_exp.delete();
    @(posedge clk); #1;
    do_read(64'h200, 13'h1205, 0, 1'b0);

    // Request held high through RWAIT/RBURST
    do_read(64'h1000, 13'h1077, 2, 1'b1);

    // Randomized mix of writes and aliased reads
    for (int it = 0; it < 24; it++) begin
      if (($urandom_range(0, 2) == 0) || wr_addrs.size() < 2) begin
        for (int b = 0; b < BEATS; b++) d[b] = {$urandom, $urandom};
        do_write({$urandom, $urandom}, TW'($urandom) & 13'h0FFF, d);
      end else begin
        a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        a = (a & ~64'h3F) + 64'($urandom_range(0, 63)) + (64'($urandom) << 15);
        do_read(a, TW'($urandom) | 13'h1000, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk(q_exp.size() == 0, "queue_drained", 64'(q_exp.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
